// File: rtl/spsram_bist.sv
// ---------------------------------------------------------------------------
// spsram_bist
//   March-style built-in self test for a single-port SRAM with a 1-cycle read
//   latency. One run walks the array as:
//     W0   : write P, addresses 0..N-1                 (N cycles)
//     R0W1 : per address ascending, read P then write ~P (2N cycles)
//     R1   : read ~P, addresses N-1..0                 (N cycles)
//     CHK  : no access, compare the last read word     (1 cycle)
//     DONE : o_done pulse, verdict published           (1 cycle)
//   The total is 4N+2 cycles, so o_done is high in the (4N+2)th cycle after
//   the edge that accepted start.
//
// Request/completion protocol: i_start is a level request that is sampled only
// while the engine is idle (o_busy=0 and o_done=0); it is accepted on the
// first rising edge in IDLE where it is 1, and is ignored in every other
// state. Completion is the single-cycle o_done pulse; o_pass/o_fail and the
// error capture registers hold their values until the next accepted start.
//
// Ports
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : test request
//   i_pattern         : background pattern P, latched when start is accepted
//   o_mem_*           : SRAM data/address/write-enable/chip-enable/output-enable
//   i_mem_data        : SRAM read data, valid the cycle after a read cycle
//   o_busy            : high from W0 through CHK
//   o_done            : one-cycle completion pulse
//   o_pass, o_fail    : verdict
//   o_err_cnt         : saturating mismatch count
//   o_err_addr/data   : address and read data of the first mismatch
//   o_dbg_state       : current FSM state encoding, for observation only
// ---------------------------------------------------------------------------
module spsram_bist #(
  parameter int BW_DATA = 32,
  parameter int BW_ADDR = 5
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [BW_DATA-1:0] i_pattern,
  output logic [BW_DATA-1:0] o_mem_data,
  output logic [BW_ADDR-1:0] o_mem_addr,
  output logic               o_mem_wen,
  output logic               o_mem_cen,
  output logic               o_mem_oen,
  input  logic [BW_DATA-1:0] i_mem_data,
  output logic               o_busy,
  output logic               o_done,
  output logic               o_pass,
  output logic               o_fail,
  output logic [BW_ADDR:0]   o_err_cnt,
  output logic [BW_ADDR-1:0] o_err_addr,
  output logic [BW_DATA-1:0] o_err_data,
  output logic [2:0]         o_dbg_state
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_W0   = 3'd1;
  localparam logic [2:0] S_R0W1 = 3'd2;
  localparam logic [2:0] S_R1   = 3'd3;
  localparam logic [2:0] S_CHK  = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

  localparam logic [BW_ADDR-1:0] ADDR_MAX = '1;
  localparam logic [BW_ADDR:0]   CNT_MAX  = '1;

  logic [2:0]         state_q, state_d;
  logic [BW_ADDR-1:0] addr_q, addr_d;
  logic               rw_phase_q, rw_phase_d;   // R0W1: 0 = read, 1 = write
  logic [BW_DATA-1:0] pat_q, pat_d;
  logic               pend_q, pend_d;           // a read is awaiting compare
  logic [BW_DATA-1:0] exp_q, exp_d;             // expected word of that read
  logic [BW_ADDR-1:0] chk_addr_q, chk_addr_d;   // address of that read
  logic [BW_ADDR:0]   err_cnt_q, err_cnt_d;
  logic [BW_ADDR-1:0] err_addr_q, err_addr_d;
  logic [BW_DATA-1:0] err_data_q, err_data_d;
  logic               pass_q, pass_d;
  logic               fail_q, fail_d;

  logic               rd_cyc;
  logic               wr_cyc;
  logic [BW_DATA-1:0] wr_val;
  logic [BW_DATA-1:0] rd_exp;
  logic               mismatch;

  // Memory access decode straight from the state; non-access cycles drive
  // every SRAM output to zero.
  always_comb begin
    rd_cyc = ((state_q == S_R0W1) && !rw_phase_q) || (state_q == S_R1);
    wr_cyc = (state_q == S_W0) || ((state_q == S_R0W1) && rw_phase_q);
    wr_val = (state_q == S_W0) ? pat_q : ~pat_q;
    rd_exp = (state_q == S_R1) ? ~pat_q : pat_q;
  end

  assign o_mem_cen  = rd_cyc | wr_cyc;
  assign o_mem_wen  = wr_cyc;
  assign o_mem_oen  = rd_cyc;
  assign o_mem_addr = (rd_cyc | wr_cyc) ? addr_q : '0;
  assign o_mem_data = wr_cyc ? wr_val : '0;

  // Read data of the previous cycle is checked against the registered
  // expectation; pend_q gates out cycles that carry no read result.
  assign mismatch = pend_q && (i_mem_data != exp_q);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rw_phase_d = rw_phase_q;
    pat_d      = pat_q;
    pend_d     = rd_cyc;
    exp_d      = rd_exp;
    chk_addr_d = addr_q;
    err_cnt_d  = err_cnt_q;
    err_addr_d = err_addr_q;
    err_data_d = err_data_q;
    pass_d     = pass_q;
    fail_d     = fail_q;

    if (mismatch) begin
      if (err_cnt_q != CNT_MAX) begin
        err_cnt_d = err_cnt_q + 1'b1;
      end
      // The count never wraps back to zero, so zero means "no mismatch yet".
      if (err_cnt_q == '0) begin
        err_addr_d = chk_addr_q;
        err_data_d = i_mem_data;
      end
    end

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d    = S_W0;
          addr_d     = '0;
          rw_phase_d = 1'b0;
          pat_d      = i_pattern;
          err_cnt_d  = '0;
          err_addr_d = '0;
          err_data_d = '0;
          pass_d     = 1'b0;
          fail_d     = 1'b0;
        end
      end
      S_W0: begin
        if (addr_q == ADDR_MAX) begin
          state_d    = S_R0W1;
          addr_d     = '0;
          rw_phase_d = 1'b0;
        end else begin
          addr_d = addr_q + 1'b1;
        end
      end
      S_R0W1: begin
        rw_phase_d = ~rw_phase_q;
        if (rw_phase_q) begin
          if (addr_q == ADDR_MAX) begin
            state_d = S_R1;
            addr_d  = ADDR_MAX;   // R1 walks downward from the top address
          end else begin
            addr_d = addr_q + 1'b1;
          end
        end
      end
      S_R1: begin
        if (addr_q == '0) begin
          state_d = S_CHK;
        end else begin
          addr_d = addr_q - 1'b1;
        end
      end
      S_CHK: begin
        // Verdict uses the count including the final compare made this cycle.
        state_d = S_DONE;
        pass_d  = (err_cnt_d == '0);
        fail_d  = (err_cnt_d != '0);
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      rw_phase_q <= 1'b0;
      pat_q      <= '0;
      pend_q     <= 1'b0;
      exp_q      <= '0;
      chk_addr_q <= '0;
      err_cnt_q  <= '0;
      err_addr_q <= '0;
      err_data_q <= '0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rw_phase_q <= rw_phase_d;
      pat_q      <= pat_d;
      pend_q     <= pend_d;
      exp_q      <= exp_d;
      chk_addr_q <= chk_addr_d;
      err_cnt_q  <= err_cnt_d;
      err_addr_q <= err_addr_d;
      err_data_q <= err_data_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
    end
  end

  assign o_busy      = (state_q == S_W0) || (state_q == S_R0W1) ||
                       (state_q == S_R1) || (state_q == S_CHK);
  assign o_done      = (state_q == S_DONE);
  assign o_pass      = pass_q;
  assign o_fail      = fail_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_err_addr  = err_addr_q;
  assign o_err_data  = err_data_q;
  assign o_dbg_state = state_q;

endmodule

// File: tb/tb_spsram_bist.sv
// ---------------------------------------------------------------------------
// tb_spsram_bist
//   Bench for spsram_bist with N = 32. A behavioural 1-cycle SRAM model with
//   selectable faults answers the DUT's reads. Every run pushes the full
//   expected per-cycle SRAM access trace into exp_q; a negedge scoreboard pops
//   and compares it while the run proceeds. Scenario tasks check done timing,
//   busy, verdict and error capture inline.
// ---------------------------------------------------------------------------
module tb_spsram_bist;

  localparam int BW_DATA = 32;
  localparam int BW_ADDR = 5;
  localparam int N       = 32;
  localparam int RUN_LEN = 4 * N + 2;
  localparam int EW      = 3 + BW_ADDR + BW_DATA;

  logic               i_clk = 1'b0;
  logic               i_rst = 1'b1;
  logic               i_start = 1'b0;
  logic [BW_DATA-1:0] i_pattern = '0;
  logic [BW_DATA-1:0] o_mem_data;
  logic [BW_ADDR-1:0] o_mem_addr;
  logic               o_mem_wen, o_mem_cen, o_mem_oen;
  logic [BW_DATA-1:0] i_mem_data;
  logic               o_busy, o_done, o_pass, o_fail;
  logic [BW_ADDR:0]   o_err_cnt;
  logic [BW_ADDR-1:0] o_err_addr;
  logic [BW_DATA-1:0] o_err_data;
  logic [2:0]         o_dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [EW-1:0] exp_q[$];
  logic          sb_armed = 1'b0;
  logic [EW-1:0] sb_e, sb_a;

  int            mem_mode = 0;   // 0 ideal, 1 bit0 stuck-at-0 @7, 2 DEADBEEF
  logic [31:0]   mem [N];
  logic [31:0]   rd_q = '0;

  // ---------------- clock ----------------
  always #5 i_clk = ~i_clk;

  spsram_bist #(.BW_DATA(BW_DATA), .BW_ADDR(BW_ADDR)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_start    (i_start),
    .i_pattern  (i_pattern),
    .o_mem_data (o_mem_data),
    .o_mem_addr (o_mem_addr),
    .o_mem_wen  (o_mem_wen),
    .o_mem_cen  (o_mem_cen),
    .o_mem_oen  (o_mem_oen),
    .i_mem_data (i_mem_data),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_pass     (o_pass),
    .o_fail     (o_fail),
    .o_err_cnt  (o_err_cnt),
    .o_err_addr (o_err_addr),
    .o_err_data (o_err_data),
    .o_dbg_state(o_dbg_state)
  );

  // ---------------- SRAM model ----------------
  always @(posedge i_clk) begin
    if (o_mem_cen && o_mem_wen) mem[o_mem_addr] <= o_mem_data;
    if (o_mem_cen && !o_mem_wen && o_mem_oen) begin
      if (mem_mode == 2)                             rd_q <= 32'hDEADBEEF;
      else if (mem_mode == 1 && o_mem_addr == 5'd7)  rd_q <= mem[o_mem_addr] & ~32'h1;
      else                                           rd_q <= mem[o_mem_addr];
    end
  end
  assign i_mem_data = rd_q;

  // ---------------- scoreboard ----------------
  always @(negedge i_clk) begin
    if (sb_armed && exp_q.size() > 0) begin
      sb_e = exp_q.pop_front();
      sb_a = {o_mem_cen, o_mem_wen, o_mem_oen, o_mem_addr, o_mem_data};
      if (sb_e[EW-1] && !sb_e[EW-2]) sb_a[BW_DATA-1:0] = '0;  // data unspecified on reads
      n_cmp++;
      if (sb_a !== sb_e) begin
        n_err++;
        $display("FAIL mem_trace: got cen/wen/oen/addr/data %h expected %h", sb_a, sb_e);
      end
      if (exp_q.size() == 0) sb_armed = 1'b0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_trace(input logic [31:0] p);
    logic [4:0] av;
    for (int a = 0; a < N; a++) begin
      av = a[4:0];
      exp_q.push_back({3'b110, av, p});
    end
    for (int a = 0; a < N; a++) begin
      av = a[4:0];
      exp_q.push_back({3'b101, av, 32'h0});
      exp_q.push_back({3'b110, av, ~p});
    end
    for (int a = N - 1; a >= 0; a--) begin
      av = a[4:0];
      exp_q.push_back({3'b101, av, 32'h0});
    end
    exp_q.push_back('0);  // CHK
    exp_q.push_back('0);  // DONE
  endtask

  // Returns after the accepting edge; the next negedge is run cycle 1.
  task automatic start_run(input logic [31:0] p);
    @(negedge i_clk);
    i_pattern = p;
    i_start   = 1'b1;
    exp_q.delete();
    push_trace(p);
    @(posedge i_clk);
    #1;
    i_start  = 1'b0;
    sb_armed = 1'b1;
  endtask

  task automatic wait_done(output int at, output int pulses,
                           output logic busy_c1, output logic busy_pre,
                           output logic busy_done);
    at = 0; pulses = 0; busy_c1 = 1'bx; busy_pre = 1'bx; busy_done = 1'bx;
    for (int c = 1; c <= RUN_LEN + 20; c++) begin
      @(negedge i_clk);
      if (o_done === 1'b1) begin
        pulses++;
        if (at == 0) at = c;
      end
      if (c == 1)           busy_c1   = o_busy;
      if (c == RUN_LEN - 1) busy_pre  = o_busy;
      if (c == RUN_LEN)     busy_done = o_busy;
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset;
    i_rst = 1'b1;
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    n_cmp++;
    if ({o_busy, o_done, o_pass, o_fail} !== 4'b0000) begin
      n_err++; $display("FAIL reset_flags: got %b expected 0000", {o_busy, o_done, o_pass, o_fail});
    end
    n_cmp++;
    if ({o_err_cnt, o_err_addr, o_err_data} !== '0) begin
      n_err++; $display("FAIL reset_results: got %h/%h/%h expected 0", o_err_cnt, o_err_addr, o_err_data);
    end
    n_cmp++;
    if ({o_mem_cen, o_mem_wen, o_mem_oen, o_mem_addr, o_mem_data} !== '0) begin
      n_err++; $display("FAIL reset_mem: got cen %b wen %b oen %b addr %h data %h expected 0",
                        o_mem_cen, o_mem_wen, o_mem_oen, o_mem_addr, o_mem_data);
    end
    i_rst = 1'b0;
  endtask

  task automatic test_ideal;
    int at, pulses;
    logic b1, bp, bd;
    mem_mode = 0;
    start_run(32'hA5A5A5A5);
    wait_done(at, pulses, b1, bp, bd);
    n_cmp++;
    if (at != RUN_LEN) begin n_err++; $display("FAIL ideal_done_cycle: got %0d expected %0d", at, RUN_LEN); end
    n_cmp++;
    if (pulses != 1) begin n_err++; $display("FAIL ideal_done_pulses: got %0d expected 1", pulses); end
    n_cmp++;
    if ({b1, bp, bd} !== 3'b110) begin n_err++; $display("FAIL ideal_busy: got %b expected 110", {b1, bp, bd}); end
    n_cmp++;
    if ({o_pass, o_fail} !== 2'b10) begin n_err++; $display("FAIL ideal_verdict: got %b expected 10", {o_pass, o_fail}); end
    n_cmp++;
    if (o_err_cnt !== 6'd0) begin n_err++; $display("FAIL ideal_err_cnt: got %0d expected 0", o_err_cnt); end
    n_cmp++;
    if (exp_q.size() != 0) begin n_err++; $display("FAIL ideal_trace_len: got %0d left expected 0", exp_q.size()); end
  endtask

  task automatic test_stuck_bit;
    int at, pulses;
    logic b1, bp, bd;
    mem_mode = 1;
    start_run(32'h00000001);
    wait_done(at, pulses, b1, bp, bd);
    n_cmp++;
    if (at != RUN_LEN) begin n_err++; $display("FAIL stuck_done_cycle: got %0d expected %0d", at, RUN_LEN); end
    n_cmp++;
    if (o_err_cnt !== 6'd1) begin n_err++; $display("FAIL stuck_err_cnt: got %0d expected 1", o_err_cnt); end
    n_cmp++;
    if (o_err_addr !== 5'd7) begin n_err++; $display("FAIL stuck_err_addr: got %0d expected 7", o_err_addr); end
    n_cmp++;
    if (o_err_data !== 32'h0) begin n_err++; $display("FAIL stuck_err_data: got %h expected 00000000", o_err_data); end
    n_cmp++;
    if ({o_pass, o_fail} !== 2'b01) begin n_err++; $display("FAIL stuck_verdict: got %b expected 01", {o_pass, o_fail}); end
  endtask

  task automatic test_saturate;
    int at, pulses;
    logic b1, bp, bd;
    mem_mode = 2;
    start_run(32'h00000001);
    wait_done(at, pulses, b1, bp, bd);
    n_cmp++;
    if (at != RUN_LEN) begin n_err++; $display("FAIL sat_done_cycle: got %0d expected %0d", at, RUN_LEN); end
    n_cmp++;
    if (o_err_cnt !== 6'd63) begin n_err++; $display("FAIL sat_err_cnt: got %0d expected 63", o_err_cnt); end
    n_cmp++;
    if (o_err_addr !== 5'd0) begin n_err++; $display("FAIL sat_err_addr: got %0d expected 0", o_err_addr); end
    n_cmp++;
    if (o_err_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL sat_err_data: got %h expected deadbeef", o_err_data); end
    n_cmp++;
    if ({o_pass, o_fail} !== 2'b01) begin n_err++; $display("FAIL sat_verdict: got %b expected 01", {o_pass, o_fail}); end
  endtask

  task automatic test_reset_midrun;
    int at, pulses;
    logic b1, bp, bd;
    logic [31:0] p;
    mem_mode = 2;
    start_run(32'h00000001);
    repeat (50) @(negedge i_clk);
    // Reads at cycles 33,35,..,47 have been compared by cycle 50.
    n_cmp++;
    if (o_err_cnt !== 6'd8) begin n_err++; $display("FAIL midrun_pre_err_cnt: got %0d expected 8", o_err_cnt); end
    i_rst = 1'b1;
    @(posedge i_clk);
    #1;
    exp_q.delete();
    sb_armed = 1'b0;
    @(negedge i_clk);
    n_cmp++;
    if ({o_mem_cen, o_busy, o_done, o_pass, o_fail} !== 5'b00000) begin
      n_err++; $display("FAIL midrun_flags: got %b expected 00000", {o_mem_cen, o_busy, o_done, o_pass, o_fail});
    end
    n_cmp++;
    if ({o_err_cnt, o_err_addr, o_err_data} !== '0) begin
      n_err++; $display("FAIL midrun_results: got %h/%h/%h expected 0", o_err_cnt, o_err_addr, o_err_data);
    end
    i_rst    = 1'b0;
    mem_mode = 0;
    p = $urandom();
    start_run(p);
    wait_done(at, pulses, b1, bp, bd);
    n_cmp++;
    if (at != RUN_LEN) begin n_err++; $display("FAIL midrun_done_cycle: got %0d expected %0d", at, RUN_LEN); end
    n_cmp++;
    if ({o_pass, o_fail, o_err_cnt} !== {2'b10, 6'd0}) begin
      n_err++; $display("FAIL midrun_verdict: got pass %b fail %b cnt %0d expected 1/0/0", o_pass, o_fail, o_err_cnt);
    end
  endtask

  task automatic test_start_ignored;
    int at, pulses, busy_after;
    at = 0; pulses = 0; busy_after = 0;
    mem_mode = 0;
    start_run(32'h3C3C_0FF0 ^ $urandom_range(0, 255));
    for (int c = 1; c <= RUN_LEN + 20; c++) begin
      @(negedge i_clk);
      if (o_done === 1'b1) begin
        pulses++;
        if (at == 0) at = c;
      end
      if (c > RUN_LEN && o_busy !== 1'b0) busy_after++;
      // Start held across an R0W1 edge and across the DONE edge.
      if (c == 50 || c == RUN_LEN) i_start = 1'b1;
      else                         i_start = 1'b0;
    end
    n_cmp++;
    if (at != RUN_LEN) begin n_err++; $display("FAIL ignore_done_cycle: got %0d expected %0d", at, RUN_LEN); end
    n_cmp++;
    if (pulses != 1) begin n_err++; $display("FAIL ignore_done_pulses: got %0d expected 1", pulses); end
    n_cmp++;
    if (busy_after != 0) begin n_err++; $display("FAIL ignore_restart: got %0d busy cycles expected 0", busy_after); end
    n_cmp++;
    if ({o_pass, o_fail} !== 2'b10) begin n_err++; $display("FAIL ignore_verdict: got %b expected 10", {o_pass, o_fail}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_ideal();
    test_stuck_bit();
    test_saturate();
    test_reset_midrun();
    test_start_ignored();
    repeat (2) @(negedge i_clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/spsram_bist.md
SPSRAM_BIST -- requirements
Module: spsram_bist

Interface
REQ-001 SHALL have parameter BW_DATA, default 32: memory word width.
REQ-002 SHALL have parameter BW_ADDR, default 5: memory address width; depth = 2^BW_ADDR.
REQ-003 SHALL have port i_clk, input, 1 bit: single clock; all state changes on the rising edge.
REQ-004 SHALL have port i_rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have port i_start, input, 1 bit: test request, sampled only in IDLE.
REQ-006 SHALL have port i_pattern, input, BW_DATA bits: background pattern P, latched when start is accepted.
REQ-007 SHALL have port o_mem_data, output, BW_DATA bits: SRAM write data.
REQ-008 SHALL have port o_mem_addr, output, BW_ADDR bits: SRAM address.
REQ-009 SHALL have ports o_mem_wen, o_mem_cen and o_mem_oen, outputs, 1 bit each, all active-high: SRAM write enable, chip enable and output enable.
REQ-010 SHALL have port i_mem_data, input, BW_DATA bits: SRAM read data, valid exactly 1 cycle after a read cycle.
REQ-011 SHALL have port o_busy, output, 1 bit: test in progress.
REQ-012 SHALL have port o_done, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have ports o_pass and o_fail, outputs, 1 bit each: test verdict, held until the next accepted start.
REQ-014 SHALL have port o_err_cnt, output, BW_ADDR+1 bits: mismatch count, saturating.
REQ-015 SHALL have port o_err_addr, output, BW_ADDR bits: address of the first mismatch.
REQ-016 SHALL have port o_err_data, output, BW_DATA bits: read data at the first mismatch.

Function
REQ-017 SHALL implement FSM states IDLE, W0, R0W1, R1, CHK and DONE.
REQ-018 SHALL, in IDLE with i_start=1, latch P, clear all result outputs and go to W0; i_start SHALL be ignored in every other state.
REQ-019 SHALL, in W0, write P to addresses 0..N-1 ascending at one write per cycle (N cycles).
REQ-020 SHALL, in R0W1, per address ascending, spend a read cycle expecting P and then a write cycle writing ~P (2N cycles).
REQ-021 SHALL, in R1, read addresses N-1..0 descending at one read per cycle, expecting ~P (N cycles).
REQ-022 SHALL spend exactly one cycle in CHK, with no memory access, to compare the last read.
REQ-023 SHALL, in DONE, assert o_done for one cycle, drive o_pass = (err_cnt==0) and o_fail = ~o_pass, then return to IDLE.
REQ-024 SHALL drive read cycles as cen=1, wen=0, oen=1; write cycles as cen=1, wen=1, oen=0, o_mem_data=write value; all other cycles as cen=wen=oen=0, addr=0, o_mem_data=0.
REQ-025 SHALL register each read's expected value and a pending flag, and compare i_mem_data against them on the following cycle.
REQ-026 SHALL, on a mismatch, increment o_err_cnt, saturating at 2^(BW_ADDR+1)-1.
REQ-027 SHALL capture o_err_addr and o_err_data only on the first mismatch of a run.
REQ-028 SHALL hold o_busy=1 from W0 through CHK and 0 in IDLE and DONE.
REQ-029 SHALL deliver o_done 4N+2 cycles after the edge that accepts start (N=32 gives 130).

Reset
REQ-030 SHALL, with i_rst=1 at an edge in any state, go to IDLE, set o_busy, o_done, o_pass, o_fail, o_err_cnt, o_err_addr, o_err_data and all mem outputs to 0, and clear the pending compare.
REQ-031 SHALL, on a reset mid-run, discard all partial results; the next start SHALL run a full test.

Verification
REQ-032 SHALL cover: ideal 1-cycle SRAM model, P=0xA5A5A5A5 -> 32 writes of A5A5A5A5 to addresses 0..31, then alternating read/write of 5A5A5A5A, then reads 31..0; o_done at start+130; pass=1, err_cnt=0.
REQ-033 SHALL cover: bit 0 stuck-at-0 at address 7, P=0x00000001 -> err_cnt=1, err_addr=7, err_data=0x00000000, fail=1.
REQ-034 SHALL cover: memory model always returning 0xDEADBEEF, P=0x00000001 -> 64 mismatches saturate err_cnt at 63; err_addr=0; err_data=0xDEADBEEF.
REQ-035 SHALL cover: i_rst asserted 50 cycles into a run -> next cycle cen=0, busy=0, all results 0; a new start then completes at +130 with pass=1.
REQ-036 SHALL cover: i_start pulsed during R0W1 and in the DONE cycle -> ignored, with exactly one o_done pulse and no timing change.
